// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared request/response types, FSM states and burst encoding for the BRAM arbiter
package bram_arb_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrobe;
    logic [1:0]  burst;
    logic [7:0]  len;
  } bram_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] rdata;
  } bram_resp_t;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
endpackage

// File: rtl/bram_arb_pick.sv
// bram_arb_pick: 2-way picker, ports i_valid/d_valid/ptr(1 = d granted last) -> one-hot grant {d,i}; RR=0 gives data priority
module bram_arb_pick #(
  parameter bit RR = 1'b0
) (
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  assign grant = (i_valid && d_valid) ? ((RR && ptr) ? 2'b01 : 2'b10) : {d_valid, i_valid};
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares the BRAM wrapper (m_*) between i (read-only) and d ports per transaction with a 1-cycle bubble; clk, reset (sync active-low); BRAM_ARB_RR_EN selects round-robin over data priority
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter bit SIMULATION = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [1:0]  i_burst,
  output logic        i_ready,
  output logic        i_last,
  output logic [63:0] i_rdata,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wstrobe,
  input  logic [1:0]  d_burst,
  input  logic [7:0]  d_len,
  output logic        d_ready,
  output logic        d_last,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_wstrobe,
  output logic [1:0]  m_burst,
  output logic [7:0]  m_len,
  input  logic        m_ready,
  input  logic        m_last,
  input  logic [63:0] m_rdata
);
  arb_state_t state, prev_state;
  bram_req_t  ireq, dreq, mreq, prev_m;
  bram_resp_t mresp, idle_resp, iresp, dresp;
  logic [1:0] pick;
  logic       ptr;
  assign ireq = bram_req_t'{valid: i_valid, addr: i_addr, wdata: 64'd0, wstrobe: 8'd0, burst: i_burst, len: i_len};
  assign dreq = bram_req_t'{valid: d_valid, addr: d_addr, wdata: d_wdata, wstrobe: d_wstrobe, burst: d_burst, len: d_len};
  assign mreq = (state == GRANT_I) ? ireq : (state == GRANT_D) ? dreq : '0;
  assign {m_valid, m_addr, m_wdata, m_wstrobe, m_burst, m_len} = mreq;
  assign mresp     = bram_resp_t'{ready: m_ready, last: m_last, rdata: m_rdata};
  assign idle_resp = bram_resp_t'{ready: 1'b0, last: 1'b0, rdata: m_rdata};
  assign iresp = (state == GRANT_I) ? mresp : idle_resp;
  assign dresp = (state == GRANT_D) ? mresp : idle_resp;
  assign {i_ready, i_last, i_rdata} = iresp;
  assign {d_ready, d_last, d_rdata} = dresp;
`ifdef BRAM_ARB_RR_EN
  bram_arb_pick #(.RR(1'b1)) u_pick (.i_valid(i_valid), .d_valid(d_valid), .ptr(ptr), .grant(pick));
  // ptr = 1 means data was granted last, so instruction wins the first tie after reset
  always_ff @(posedge clk)
    if (!reset) ptr <= 1'b1;
    else if (state == IDLE && |pick) ptr <= pick[1];
`else
  assign ptr = 1'b0;
  bram_arb_pick #(.RR(1'b0)) u_pick (.i_valid(i_valid), .d_valid(d_valid), .ptr(ptr), .grant(pick));
`endif
  // in a grant state mreq.valid is the owner's valid, so a dropped valid aborts
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else if (state == IDLE) state <= pick[1] ? GRANT_D : pick[0] ? GRANT_I : IDLE;
    else if (!mreq.valid || (m_ready && m_last)) state <= IDLE;
  always_ff @(posedge clk) begin
    prev_state <= state;
    prev_m <= mreq;
    if (SIMULATION && reset && state != IDLE && state == prev_state && prev_m.valid && mreq.valid)
      assert (mreq == prev_m);
  end
endmodule
